resp_misr_checker: RTL and testbench

- Synthesizable response-capture block for the fuzz harness: the consuming end of the stimulus/response path.
- It accepts the DUT's wide output word, one vector per handshake, and compacts each word into a 32-bit MISR signature, 32 bits per cycle.
- On the vector flagged as last, it compares the signature and the vector count against expected values and reports pass or fail.
- It replaces per-cycle $strobe dumps when comparing Yosys-synthesized and reference netlists in hardware or in long simulations.

---
 rtl/resp_chk_pkg.sv | 9 +
 rtl/resp_misr_checker_misr_step.sv | 11 +
 rtl/resp_misr_checker.sv | 84 ++++++++
 tb/tb_resp_misr_checker.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/resp_chk_pkg.sv
// resp_chk_pkg: shared state encoding, default MISR constants and ceil-divide helper
package resp_chk_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_FOLD, S_CHECK, S_DONE} state_t;
  localparam logic [31:0] DEF_POLY = 32'h04C11DB7;
  localparam logic [31:0] DEF_SEED = 32'h00000000;
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction
endpackage

// File: rtl/resp_misr_checker_misr_step.sv
// misr_step: one combinational MISR update, shift left with poly feedback xor chunk
module misr_step #(
  parameter int SIGW = 32
) (
  input  logic [SIGW-1:0] i_sig,
  input  logic [SIGW-1:0] i_chunk,
  input  logic [SIGW-1:0] i_poly,
  output logic [SIGW-1:0] o_sig
);
  assign o_sig = {i_sig[SIGW-2:0], 1'b0} ^ (i_sig[SIGW-1] ? i_poly : '0) ^ i_chunk;
endmodule

// File: rtl/resp_misr_checker.sv
// resp_misr_checker: folds each wide response word into a MISR signature and checks signature and count on the last vector
module resp_misr_checker
  import resp_chk_pkg::*;
#(
  parameter int W = 385,
  parameter int SIGW = 32,
  parameter logic [SIGW-1:0] POLY = DEF_POLY,
  parameter logic [SIGW-1:0] SEED = DEF_SEED,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            vec_valid,
  input  logic            vec_last,
  input  logic [W-1:0]    vec_data,
  output logic            vec_ready,
  input  logic [SIGW-1:0] expect_sig,
  input  logic [CNTW-1:0] expect_cnt,
  output logic [SIGW-1:0] sig,
  output logic [CNTW-1:0] vec_cnt,
  output logic            busy,
  output logic            done,
  output logic            pass
);
  localparam int NCHUNK = ceil_div(W, SIGW);
  localparam int HW = NCHUNK * SIGW;
  localparam int IW = $clog2(NCHUNK + 1);
  state_t          r_state;
  logic [HW-1:0]   r_hold;
  logic [IW-1:0]   r_idx;
  logic            r_last;
  logic            r_pass;
  logic [SIGW-1:0] r_sig;
  logic [CNTW-1:0] r_cnt;
  logic [SIGW-1:0] w_sig_next;
  logic            w_restart;
  logic            w_take;
  logic            w_fold_end;
  misr_step #(.SIGW(SIGW)) u_step (
    .i_sig  (r_sig),
    .i_chunk(r_hold[SIGW-1:0]),
    .i_poly (POLY),
    .o_sig  (w_sig_next)
  );
  assign w_restart  = start && (r_state == S_IDLE || r_state == S_ARMED || r_state == S_DONE);
  assign w_take     = vec_valid && r_state == S_ARMED;
  assign w_fold_end = r_idx == IW'(NCHUNK - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sig   <= SEED;
      r_cnt   <= '0;
      r_pass  <= 1'b0;
      r_idx   <= '0;
      r_hold  <= '0;
      r_last  <= 1'b0;
    end else if (w_restart) begin
      r_state <= S_ARMED;
      r_sig   <= SEED;
      r_cnt   <= '0;
      r_pass  <= 1'b0;
    end else if (w_take) begin
      r_state <= S_FOLD;
      r_hold  <= HW'(vec_data);
      r_last  <= vec_last;
      r_cnt   <= &r_cnt ? r_cnt : r_cnt + 1'b1;
      r_idx   <= '0;
    end else if (r_state == S_FOLD) begin
      r_sig   <= w_sig_next;
      r_hold  <= r_hold >> SIGW;
      r_idx   <= r_idx + 1'b1;
      if (w_fold_end) r_state <= r_last ? S_CHECK : S_ARMED;
    end else if (r_state == S_CHECK) begin
      r_pass  <= r_sig == expect_sig && r_cnt == expect_cnt;
      r_state <= S_DONE;
    end
  assign sig       = r_sig;
  assign vec_cnt   = r_cnt;
  assign pass      = r_pass;
  assign vec_ready = r_state == S_ARMED;
  assign busy      = r_state == S_ARMED || r_state == S_FOLD || r_state == S_CHECK;
  assign done      = r_state == S_DONE;
endmodule

// File: tb/tb_resp_misr_checker.sv
// tb_resp_misr_checker: directed checks of resp_misr_checker at W=32, W=64 and the default W=385
module tb_resp_misr_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic vv = 1'b0;
  logic vl = 1'b0;
  logic [384:0] vd = '0;
  logic [31:0] es = '0;
  logic [15:0] ec = '0;
  logic a_ready, a_busy, a_done, a_pass;
  logic b_ready, b_busy, b_done, b_pass;
  logic c_ready, c_busy, c_done, c_pass;
  logic [31:0] a_sig, b_sig, c_sig;
  logic [15:0] a_cnt, b_cnt, c_cnt;
  logic [31:0] m;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  resp_misr_checker #(.W(32)) u32 (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vv), .vec_last(vl), .vec_data(vd[31:0]),
    .vec_ready(a_ready), .expect_sig(es), .expect_cnt(ec), .sig(a_sig), .vec_cnt(a_cnt),
    .busy(a_busy), .done(a_done), .pass(a_pass)
  );
  resp_misr_checker #(.W(64)) u64 (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vv), .vec_last(vl), .vec_data(vd[63:0]),
    .vec_ready(b_ready), .expect_sig(es), .expect_cnt(ec), .sig(b_sig), .vec_cnt(b_cnt),
    .busy(b_busy), .done(b_done), .pass(b_pass)
  );
  resp_misr_checker u385 (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vv), .vec_last(vl), .vec_data(vd),
    .vec_ready(c_ready), .expect_sig(es), .expect_cnt(ec), .sig(c_sig), .vec_cnt(c_cnt),
    .busy(c_busy), .done(c_done), .pass(c_pass)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    start = 1'b0;
    vv = 1'b0;
    vl = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
  endtask
  function automatic logic [31:0] fold(input logic [31:0] s, input logic [384:0] d);
    logic [415:0] t;
    t = {31'b0, d};
    for (int j = 0; j < 13; j++)
      s = {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ t[j*32 +: 32];
    return s;
  endfunction
  function automatic logic [384:0] pat(input int k);
    logic [415:0] t;
    for (int j = 0; j < 13; j++)
      t[j*32 +: 32] = (32'(k + 1) * 32'h9E3779B9) ^ (32'(j) * 32'h01010101);
    t[384] = k[0];
    return t[384:0];
  endfunction
  task automatic wait_done385;
    int n;
    n = 0;
    while (!c_done && n < 100) begin
      tick;
      n++;
    end
    chk("c_done_timeout", c_done, 1);
  endtask
  task automatic feed385(input int nv, input int base);
    int n, cyc, lastc;
    logic acc;
    n = 0;
    cyc = 0;
    lastc = 0;
    m = 32'h0;
    vd = pat(base);
    vl = nv == 1;
    vv = 1'b1;
    while (n < nv && cyc < nv * 14 + 20) begin
      acc = c_ready;
      if (acc) begin
        m = fold(m, vd);
        n++;
        if (n > 1) chk("c_gap", 64'(cyc - lastc), 14);
        lastc = cyc;
      end
      tick;
      cyc++;
      if (acc) begin
        vd = pat(base + n);
        vl = n == nv - 1;
        vv = n < nv;
      end
    end
    vv = 1'b0;
    chk("c_accepted", 64'(n), 64'(nv));
    es = m;
    ec = 16'(nv);
    wait_done385;
    chk("c_sig", c_sig, m);
    chk("c_cnt", c_cnt, 64'(nv));
    chk("c_pass", c_pass, 1);
  endtask
  task automatic run32(input logic [15:0] ecnt, input logic exp_pass);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("a_armed_ready", a_ready, 1);
    chk("a_done_fall", a_done, 0);
    chk("a_cnt_clr", a_cnt, 0);
    es = 32'h04C11DB7;
    ec = ecnt;
    vd = 385'h80000000;
    vl = 1'b0;
    vv = 1'b1;
    tick;
    vv = 1'b0;
    chk("a_fold_ready", a_ready, 0);
    tick;
    chk("a_sig1", a_sig, 32'h80000000);
    vd = '0;
    vl = 1'b1;
    vv = 1'b1;
    tick;
    vv = 1'b0;
    tick;
    chk("a_sig2", a_sig, 32'h04C11DB7);
    tick;
    chk("a_done2", a_done, 1);
    chk("a_cnt2", a_cnt, 2);
    chk("a_pass2", a_pass, 64'(exp_pass));
  endtask
  initial begin
    tick;
    chk("rst_sig", c_sig, 0);
    chk("rst_cnt", c_cnt, 0);
    chk("rst_ready", c_ready, 0);
    chk("rst_busy", c_busy, 0);
    chk("rst_done", c_done, 0);
    chk("rst_pass", c_pass, 0);
    rst_n = 1'b1;
    tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("a_busy_armed", a_busy, 1);
    vd = 385'h1;
    vl = 1'b1;
    vv = 1'b1;
    es = 32'h1;
    ec = 16'h1;
    tick;
    vv = 1'b0;
    tick;
    chk("a1_sig", a_sig, 32'h1);
    tick;
    chk("a1_done", a_done, 1);
    chk("a1_busy", a_busy, 0);
    chk("a1_cnt", a_cnt, 1);
    chk("a1_pass", a_pass, 1);
    do_reset;
    run32(16'd2, 1'b1);
    run32(16'd3, 1'b0);
    do_reset;
    start = 1'b1;
    tick;
    start = 1'b0;
    vd = 385'h00000001_00000000;
    vl = 1'b0;
    vv = 1'b1;
    tick;
    vv = 1'b0;
    chk("b_ready_lo0", b_ready, 0);
    tick;
    chk("b_ready_lo1", b_ready, 0);
    chk("b_sig_c0", b_sig, 32'h0);
    tick;
    chk("b_ready_hi", b_ready, 1);
    chk("b_sig_c1", b_sig, 32'h1);
    do_reset;
    start = 1'b1;
    tick;
    start = 1'b0;
    feed385(21, 0);
    do_reset;
    start = 1'b1;
    tick;
    start = 1'b1;
    vv = 1'b1;
    vd = pat(7);
    vl = 1'b0;
    tick;
    start = 1'b0;
    chk("c_start_wins_cnt", c_cnt, 0);
    chk("c_start_wins_ready", c_ready, 1);
    tick;
    vv = 1'b0;
    chk("c_take_cnt", c_cnt, 1);
    chk("c_take_ready", c_ready, 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (12) tick;
    chk("c_fold_start_ready", c_ready, 1);
    chk("c_fold_start_sig", c_sig, fold(32'h0, pat(7)));
    chk("c_fold_start_cnt", c_cnt, 1);
    do_reset;
    start = 1'b1;
    tick;
    start = 1'b0;
    vd = pat(50);
    vl = 1'b0;
    vv = 1'b1;
    repeat (33) tick;
    chk("c_mid_busy", c_busy, 1);
    chk("c_mid_cnt", c_cnt, 3);
    #3 rst_n = 1'b0;
    #1;
    chk("c_arst_sig", c_sig, 0);
    chk("c_arst_cnt", c_cnt, 0);
    chk("c_arst_busy", c_busy, 0);
    chk("c_arst_ready", c_ready, 0);
    vv = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    feed385(3, 50);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
